// File: rtl/mc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_fetch_ctrl_pkg
//  Brief    : Shared opcodes, state encodings and IR field positions for the
//             multi-cycle fetch/control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_fetch_ctrl_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam int IR_OP_MSB   = 7;
   localparam int IR_OP_LSB   = 6;
   localparam int IR_RS_MSB   = 5;
   localparam int IR_RS_LSB   = 4;
   localparam int IR_RT_MSB   = 3;
   localparam int IR_RT_LSB   = 2;
   localparam int IR_RD_MSB   = 1;
   localparam int IR_RD_LSB   = 0;
   localparam int IR_JOFF_MSB = 5;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_decode
//  Brief    : Combinational Moore strobe decode from (state, opcode).
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
   import mc_fetch_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [1:0] op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg
);

   always_comb begin
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      case (state)
         ST_EXEC: begin
            alu_src = (op == OP_LW) || (op == OP_SW);
         end
         ST_MEM: begin
            alu_src   = 1'b1;
            mem_read  = (op == OP_LW);
            mem_write = (op == OP_SW);
         end
         ST_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op == OP_ADD);
            mem_to_reg = (op == OP_LW);
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_fetch_ctrl
//  Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_fetch_ctrl
   import mc_fetch_ctrl_pkg::*;
#(
   parameter int IMEM_DEPTH = 32,
   parameter int PC_W       = 8
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      instruction,
   input  logic            mem_ready,
   output logic [PC_W-1:0] Read_Address,
   output logic [7:0]      IR,
   output logic            RegWrite,
   output logic            RegDst,
   output logic            ALUSrc,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            MemtoReg,
   output logic            halted,
   output logic [2:0]      state_out
);

   localparam logic [PC_W:0] c_imem_limit = (PC_W+1)'(IMEM_DEPTH);

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [7:0]      r_ir;

   logic [1:0]      w_op;
   logic [PC_W-1:0] w_jmp_off;
   logic            w_pc_out_of_range;

   assign w_op              = r_ir[IR_OP_MSB:IR_OP_LSB];
   assign w_jmp_off         = {{(PC_W-IR_JOFF_MSB-1){r_ir[IR_JOFF_MSB]}}, r_ir[IR_JOFF_MSB:0]};
   // Extra MSB keeps the bound check correct when IMEM_DEPTH == 2^PC_W.
   assign w_pc_out_of_range = ({1'b0, r_pc} >= c_imem_limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_pc_out_of_range) begin
                  r_state <= ST_HALT;
               end else begin
                  r_ir    <= instruction;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_pc    <= r_pc + 1'b1;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               case (w_op)
                  OP_ADD:  r_state <= ST_WB;
                  OP_JMP: begin
                     r_pc    <= r_pc + w_jmp_off;
                     r_state <= ST_FETCH;
                  end
                  default: r_state <= ST_MEM;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  r_state <= (w_op == OP_LW) ? ST_WB : ST_FETCH;
               end
            end
            ST_WB: begin
               r_state <= ST_FETCH;
            end
            ST_HALT: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state      (r_state),
      .op         (w_op),
      .reg_write  (RegWrite),
      .reg_dst    (RegDst),
      .alu_src    (ALUSrc),
      .mem_read   (MemRead),
      .mem_write  (MemWrite),
      .mem_to_reg (MemtoReg)
   );

   assign Read_Address = r_pc;
   assign IR           = r_ir;
   assign halted       = (r_state == ST_HALT);
   assign state_out    = r_state;

endmodule
`default_nettype wire
